// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: controller state
// encoding and the address-width helper used to size the index buses.
package regfile_pkg;

  // state    | meaning
  // ST_CLEAR | zeroing one entry per cycle, reads forced to 0, writes ignored
  // ST_RUN   | clear finished, normal read/write service, Ready high
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } regfile_state_t;

  // Index width for an array of n entries; never narrower than one bit.
  function automatic int addrWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: applies the x0, out-of-range and
// write-bypass rules on top of the word the array currently holds.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arrayWord,
  input  logic              writeAccept,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              run,
  output logic [DATA_W-1:0] data
);

  logic inRange;

  // A full power-of-two array has no unreachable index, so skip the compare.
  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : gFull
      assign inRange = 1'b1;
    end else begin : gPartial
      assign inRange = (addr < ADDR_W'(NUM_REGS));
    end
  endgenerate

  // Priority mux: not running, x0 and holes read 0; a same-cycle write wins over stored data.
  always_comb begin
    data = '0;
    if (!run) begin
      data = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end else if (!inRange) begin
      data = '0;
    end else if ((BYPASS != 0) && writeAccept && (writeAddr == addr)) begin
      data = writeData;
    end else begin
      data = arrayWord;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file. After reset a sequencer
// zeroes every entry, one per cycle, before raising Ready; only then are
// writes accepted and stored data made visible on the read ports.
//
// state    | meaning
// ST_CLEAR | zeroing entry clrPtr this cycle; Ready low, reads 0
// ST_RUN   | normal operation; Ready high until the next RST
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = addrWidth(NUM_REGS)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WriteEn,
  input  logic [ADDR_W-1:0]          WriteAddress,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic [NUM_READ*ADDR_W-1:0] ReadAddress,
  output logic [NUM_READ*DATA_W-1:0] ReadData,
  output logic                       Ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  regfile_state_t    state;
  logic [ADDR_W-1:0] clrPtr;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              run;
  logic              writeInRange;
  logic              writeAccept;

  assign run = (state == ST_RUN);

  // Indices past the last entry exist only when NUM_REGS is not a power of two.
  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : gWrFull
      assign writeInRange = 1'b1;
    end else begin : gWrPartial
      assign writeInRange = (WriteAddress < ADDR_W'(NUM_REGS));
    end
  endgenerate

  // A write lands only in RUN, outside reset, to a real entry that is not a hardwired x0.
  assign writeAccept = run && !RST && WriteEn && writeInRange &&
                       !((ZERO_REG != 0) && (WriteAddress == '0));

  // Controller: RST restarts the clear from entry 0; the last clear cycle hands over to RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_CLEAR;
      clrPtr <= '0;
      Ready  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clrPtr == LAST_IDX) begin
            state  <= ST_RUN;
            clrPtr <= '0;
            Ready  <= 1'b1;
          end else begin
            clrPtr <= clrPtr + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          Ready <= 1'b1;
        end
        default: begin
          state  <= ST_CLEAR;
          clrPtr <= '0;
          Ready  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: the clear sequencer owns the write path until the file is running.
  always_ff @(posedge CLK) begin
    if (!RST && (state == ST_CLEAR)) begin
      mem[clrPtr] <= '0;
    end else if (writeAccept) begin
      mem[WriteAddress] <= WriteData;
    end
  end

  generate
    for (genvar i = 0; i < NUM_READ; i++) begin : gRead
      logic [ADDR_W-1:0] rdAddr;
      logic [DATA_W-1:0] rdWord;

      assign rdAddr = ReadAddress[i*ADDR_W +: ADDR_W];
      // Out-of-range indices are masked to 0 inside the port, so the raw word is don't-care there.
      assign rdWord = mem[rdAddr];

      regfile_rd_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
      ) uRdPort (
        .addr       (rdAddr),
        .arrayWord  (rdWord),
        .writeAccept(writeAccept),
        .writeAddr  (WriteAddress),
        .writeData  (WriteData),
        .run        (run),
        .data       (ReadData[i*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default build (32x32, 2 ports, x0, bypass) and a
// 24-entry, 3-port build without x0 or bypass, driven with shared write
// traffic and checked every cycle against a behavioural model.
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WriteEn = 1'b0;
  logic [4:0]  WriteAddress = '0;
  logic [31:0] WriteData = '0;
  logic [9:0]  raA = '0;
  logic [63:0] rdA;
  logic        readyA;
  logic [14:0] raB = '0;
  logic [95:0] rdB;
  logic        readyB;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] memA [32];
  logic [31:0] memB [24];
  int          clrA = 32;
  int          clrB = 24;
  bit          rdyA = 1'b0;
  bit          rdyB = 1'b0;

  always #5 CLK = ~CLK;

  regfile_mp uDutA (
    .CLK         (CLK),
    .RST         (RST),
    .WriteEn     (WriteEn),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .ReadAddress (raA),
    .ReadData    (rdA),
    .Ready       (readyA)
  );

  regfile_mp #(
    .DATA_W  (32),
    .NUM_REGS(24),
    .NUM_READ(3),
    .ZERO_REG(0),
    .BYPASS  (0)
  ) uDutB (
    .CLK         (CLK),
    .RST         (RST),
    .WriteEn     (WriteEn),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .ReadAddress (raB),
    .ReadData    (rdB),
    .Ready       (readyB)
  );

  function automatic bit acceptA();
    return rdyA && !RST && WriteEn && (WriteAddress != 0) && (int'(WriteAddress) < 32);
  endfunction

  function automatic bit acceptB();
    return rdyB && !RST && WriteEn && (int'(WriteAddress) < 24);
  endfunction

  function automatic logic [31:0] expA(input int a);
    if (!rdyA) return 32'h0;
    if (a == 0) return 32'h0;
    if (acceptA() && int'(WriteAddress) == a) return WriteData;
    return memA[a];
  endfunction

  function automatic logic [31:0] expB(input int a);
    if (!rdyB) return 32'h0;
    if (a >= 24) return 32'h0;
    return memB[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit wa, wb;
    @(negedge CLK);
    chk("readyA", {31'b0, readyA}, {31'b0, rdyA});
    chk("readyB", {31'b0, readyB}, {31'b0, rdyB});
    for (int i = 0; i < 2; i++)
      chk($sformatf("A.port%0d@%0d", i, raA[i*5 +: 5]), rdA[i*32 +: 32], expA(int'(raA[i*5 +: 5])));
    for (int i = 0; i < 3; i++)
      chk($sformatf("B.port%0d@%0d", i, raB[i*5 +: 5]), rdB[i*32 +: 32], expB(int'(raB[i*5 +: 5])));
    wa = acceptA();
    wb = acceptB();
    @(posedge CLK);
    if (RST) begin
      clrA = 32; rdyA = 1'b0;
      clrB = 24; rdyB = 1'b0;
      for (int k = 0; k < 32; k++) memA[k] = '0;
      for (int k = 0; k < 24; k++) memB[k] = '0;
    end else begin
      if (wa) memA[WriteAddress] = WriteData;
      if (wb) memB[WriteAddress] = WriteData;
      if (clrA > 0) begin clrA--; if (clrA == 0) rdyA = 1'b1; end
      if (clrB > 0) begin clrB--; if (clrB == 0) rdyB = 1'b1; end
    end
    #1;
  endtask

  task automatic setW(input bit e, input int a, input logic [31:0] d);
    WriteEn = e;
    WriteAddress = 5'(a);
    WriteData = d;
  endtask

  task automatic setRd(input int a0, input int a1, input int b0, input int b1, input int b2);
    raA = {5'(a1), 5'(a0)};
    raB = {5'(b2), 5'(b1), 5'(b0)};
  endtask

  initial begin
    for (int k = 0; k < 32; k++) memA[k] = '0;
    for (int k = 0; k < 24; k++) memB[k] = '0;

    // first edge establishes a known state before anything is compared
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // reset held two cycles, then the full clear with reads of live addresses
    setRd(5, 6, 5, 6, 23);
    tick();
    tick();
    RST = 1'b0;
    for (int c = 0; c < 34; c++) tick();
    for (int a = 0; a < 32; a += 2) begin
      setRd(a, a + 1, a, a + 1, (a + 7) % 32);
      tick();
    end

    // basic write then read from both ports
    setW(1, 5, 32'hDEADBEEF);
    setRd(1, 2, 1, 2, 3);
    tick();
    setW(0, 0, 32'h0);
    setRd(5, 5, 5, 5, 5);
    tick();

    // x0 write: dropped on the default build, stored on the no-x0 build
    setW(1, 0, 32'hFFFFFFFF);
    tick();
    setW(0, 0, 32'h0);
    setRd(0, 0, 0, 0, 0);
    tick();

    // bypass: preload x7, then overwrite while port1 reads it the same cycle
    setW(1, 7, 32'h00000055);
    tick();
    setW(1, 7, 32'h00001234);
    setRd(3, 7, 3, 7, 7);
    tick();
    setW(0, 0, 32'h0);
    tick();

    // addresses past 24 on the small build: write dropped, read 0, ports independent
    setW(1, 30, 32'hCAFEF00D);
    setRd(30, 5, 30, 5, 7);
    tick();
    setW(1, 23, 32'h0BADC0DE);
    tick();
    setW(0, 0, 32'h0);
    setRd(30, 23, 30, 23, 0);
    tick();

    // randomized traffic, reads biased towards the address being written
    for (int n = 0; n < 400; n++) begin
      int a [5];
      int w;
      w = int'($urandom_range(0, 31));
      setW(bit'($urandom_range(0, 1)), w, $urandom());
      for (int p = 0; p < 5; p++)
        a[p] = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, 31));
      setRd(a[0], a[1], a[2], a[3], a[4]);
      tick();
    end

    // reset pulse ten cycles into a clear; a write attempted during clear is lost
    setW(0, 0, 32'h0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    setW(1, 9, 32'h0000AAAA);
    setRd(9, 9, 9, 9, 9);
    for (int c = 0; c < 5; c++) tick();
    setW(0, 0, 32'h0);
    for (int c = 0; c < 30; c++) tick();
    for (int a = 0; a < 32; a += 2) begin
      setRd(a, a + 1, a, a + 1, 9);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
